// File: rtl/multiplier_if.sv
// Handshake and operand/result bundle for the shift-add multiplier.
//   i_start        : level request to begin a multiplication (master -> slave)
//   i_multiplicand : unsigned operand A, N bits (master -> slave)
//   i_multiplier   : unsigned operand B, N bits (master -> slave)
//   o_finished     : result valid, high only while the multiplier is in DONE (slave -> master)
//   o_product      : registered A*B, 2N bits (slave -> master)
//   o_overflow     : registered flag, product does not fit in N bits (slave -> master)
interface multiplier_if #(
  parameter int unsigned N = 4
);
  logic           i_start;
  logic [N-1:0]   i_multiplicand;
  logic [N-1:0]   i_multiplier;
  logic           o_finished;
  logic [2*N-1:0] o_product;
  logic           o_overflow;

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_finished, o_product, o_overflow
  );

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_finished, o_product, o_overflow
  );
endinterface

// File: rtl/multiplier.sv
// Sequential radix-2 shift-add unsigned multiplier.
// Operands are captured in IDLE on a start request; BUSY then runs exactly N
// iterations regardless of operand values, and the result is published on entry
// to DONE. DONE is held while start stays high so a held start yields one operation.
//   i_clock : clock, all state changes on the rising edge
//   i_reset : asynchronous active-high reset
//   bus     : multiplier_if slave (start, operands, finished, product, overflow)
module multiplier #(
  parameter int unsigned N = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  multiplier_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam int unsigned    CntW    = $clog2(N + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  state_e          state_q;
  logic [2*N-1:0]  mcand_q;
  logic [N-1:0]    mplier_q;
  logic [2*N-1:0]  acc_q;
  logic [2*N-1:0]  acc_d;
  logic [CntW-1:0] cnt_q;
  logic [2*N-1:0]  product_q;
  logic            overflow_q;
  logic            finished_q;

  // (2^N-1)^2 < 2^2N, so the 2N-bit sum never carries out.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            mcand_q  <= {{N{1'b0}}, bus.i_multiplicand};
            mplier_q <= bus.i_multiplier;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          // Counter ends at N, which fits in CntW bits, so it never wraps.
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            product_q  <= acc_d;
            overflow_q <= |acc_d[2*N-1:N];
            finished_q <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone: begin
          if (!bus.i_start) begin
            finished_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          finished_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_finished = finished_q;
  assign bus.o_product  = product_q;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the shift-add multiplier (N=4). Expected results come
// from a simple arithmetic model and are queued when stimulus is driven, then
// popped when o_finished is observed.
module tb_multiplier;

  localparam int unsigned N = 4;

  logic i_clock;
  logic i_reset;

  multiplier_if #(.N(N)) bus ();

  multiplier #(.N(N)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // {overflow, product}
  logic [2*N:0] sb[$];

  function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    return {(p > (2**N - 1)), p};
  endfunction

  // Counts negedges until o_finished is seen; -1 if the bound expires.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.o_finished && cycles < 40) begin
      @(negedge i_clock);
      cycles++;
    end
    if (!bus.o_finished) cycles = -1;
  endtask

  // Drives a one-cycle start pulse; returns after the capture edge.
  task automatic pulse_start(input logic [N-1:0] a, input logic [N-1:0] b);
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    bus.i_start        = 1'b1;
    sb.push_back(model(a, b));
    @(negedge i_clock);
    bus.i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset            = 1'b1;
    bus.i_start        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;
    #1;
    n_tests++;
    if (bus.o_finished !== 1'b0 || bus.o_product !== '0 || bus.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fin=%b prod=%h ovf=%b, want 0/00/0",
               bus.o_finished, bus.o_product, bus.o_overflow);
    end
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
    @(negedge i_clock);
    n_tests++;
    if (bus.o_finished !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got fin=%b, want 0", bus.o_finished);
    end
  endtask

  task automatic test_basic();
    int cycles;
    logic [2*N:0] exp;
    pulse_start(4'd3, 4'd5);
    wait_done(cycles);
    n_tests++;
    if (cycles !== N) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, want %0d", cycles, N);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if ({bus.o_overflow, bus.o_product} !== exp || bus.o_product !== 8'h0F) begin
      n_fail++;
      $display("FAIL basic_result: got ovf=%b prod=%h, want ovf=%b prod=%h",
               bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
    end
    @(negedge i_clock);
    n_tests++;
    if (bus.o_finished !== 1'b0 || bus.o_product !== 8'h0F) begin
      n_fail++;
      $display("FAIL basic_return_idle: got fin=%b prod=%h, want 0/0f",
               bus.o_finished, bus.o_product);
    end
  endtask

  task automatic test_zero();
    int cycles;
    logic [2*N:0] exp;
    logic [N-1:0] as[2] = '{4'd0, 4'd9};
    logic [N-1:0] bs[2] = '{4'd9, 4'd0};
    for (int i = 0; i < 2; i++) begin
      pulse_start(as[i], bs[i]);
      wait_done(cycles);
      n_tests++;
      if (cycles !== N) begin
        n_fail++;
        $display("FAIL zero_latency_%0d: got %0d, want %0d", i, cycles, N);
      end
      exp = (sb.size() != 0) ? sb.pop_front() : 'x;
      n_tests++;
      if ({bus.o_overflow, bus.o_product} !== exp) begin
        n_fail++;
        $display("FAIL zero_result_%0d: got ovf=%b prod=%h, want ovf=%b prod=%h", i,
                 bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
      end
      @(negedge i_clock);
    end
  endtask

  task automatic test_max();
    int cycles;
    logic [2*N:0] exp;
    pulse_start(4'd15, 4'd15);
    wait_done(cycles);
    n_tests++;
    if (cycles !== N) begin
      n_fail++;
      $display("FAIL max_latency: got %0d, want %0d", cycles, N);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if ({bus.o_overflow, bus.o_product} !== exp || bus.o_product !== 8'hE1) begin
      n_fail++;
      $display("FAIL max_result: got ovf=%b prod=%h, want ovf=%b prod=%h",
               bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
    end
    @(negedge i_clock);
  endtask

  task automatic test_input_change();
    int cycles;
    logic [2*N:0] exp;
    pulse_start(4'd4, 4'd4);
    @(negedge i_clock);
    bus.i_multiplicand = 4'd15;
    bus.i_multiplier   = 4'd15;
    n_tests++;
    if (bus.o_finished !== 1'b0 || bus.o_product !== 8'hE1 || bus.o_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_holds_result: got fin=%b prod=%h ovf=%b, want 0/e1/1",
               bus.o_finished, bus.o_product, bus.o_overflow);
    end
    wait_done(cycles);
    n_tests++;
    if (cycles !== N - 1) begin
      n_fail++;
      $display("FAIL change_latency: got %0d, want %0d", cycles, N - 1);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if ({bus.o_overflow, bus.o_product} !== exp || bus.o_product !== 8'h10) begin
      n_fail++;
      $display("FAIL change_result: got ovf=%b prod=%h, want ovf=%b prod=%h",
               bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
    end
    @(negedge i_clock);
  endtask

  task automatic test_held_start();
    int rises = 0;
    logic prev;
    logic [2*N:0] exp;
    bus.i_multiplicand = 4'd6;
    bus.i_multiplier   = 4'd7;
    bus.i_start        = 1'b1;
    sb.push_back(model(4'd6, 4'd7));
    prev = bus.o_finished;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clock);
      if (i == 10) begin
        bus.i_multiplicand = 4'd1;
        bus.i_multiplier   = 4'd1;
      end
      if (bus.o_finished && !prev) begin
        rises++;
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_tests++;
        if ({bus.o_overflow, bus.o_product} !== exp) begin
          n_fail++;
          $display("FAIL held_result: got ovf=%b prod=%h, want ovf=%b prod=%h",
                   bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
        end
      end
      prev = bus.o_finished;
    end
    n_tests++;
    if (rises !== 1 || bus.o_finished !== 1'b1 || bus.o_product !== 8'h2A) begin
      n_fail++;
      $display("FAIL held_single_op: got rises=%0d fin=%b prod=%h, want 1/1/2a",
               rises, bus.o_finished, bus.o_product);
    end
    bus.i_start = 1'b0;
    @(negedge i_clock);
    n_tests++;
    if (bus.o_finished !== 1'b0 || bus.o_product !== 8'h2A) begin
      n_fail++;
      $display("FAIL held_release: got fin=%b prod=%h, want 0/2a",
               bus.o_finished, bus.o_product);
    end
  endtask

  task automatic test_reset_midbusy();
    int cycles;
    int bad = 0;
    logic [2*N:0] exp;
    pulse_start(4'd7, 4'd7);
    @(negedge i_clock);
    #2;
    i_reset = 1'b1;
    #1;
    sb.delete();
    n_tests++;
    if (bus.o_finished !== 1'b0 || bus.o_product !== '0 || bus.o_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got fin=%b prod=%h ovf=%b, want 0/00/0",
               bus.o_finished, bus.o_product, bus.o_overflow);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clock);
      if (bus.o_finished !== 1'b0 || bus.o_product !== '0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d cycles with output activity, want 0", bad);
    end
    pulse_start(4'd2, 4'd3);
    wait_done(cycles);
    n_tests++;
    if (cycles !== N) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d, want %0d", cycles, N);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    n_tests++;
    if ({bus.o_overflow, bus.o_product} !== exp || bus.o_product !== 8'h06) begin
      n_fail++;
      $display("FAIL post_reset_result: got ovf=%b prod=%h, want ovf=%b prod=%h",
               bus.o_overflow, bus.o_product, exp[2*N], exp[2*N-1:0]);
    end
    @(negedge i_clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_input_change();
    test_held_start();
    test_reset_midbusy();
    n_tests++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port i_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_start, input, 1 bit: level request to begin a multiplication.
REQ-005 The block SHALL have port o_finished, output, 1 bit: result valid, high only in state DONE.
REQ-006 The block SHALL have port i_multiplicand, input, N bits: unsigned operand A.
REQ-007 The block SHALL have port i_multiplier, input, N bits: unsigned operand B.
REQ-008 The block SHALL have port o_product, output, 2N bits: unsigned A*B, registered.
REQ-009 The block SHALL have port o_overflow, output, 1 bit: product does not fit in N bits, i.e. o_product[2N-1:N] != 0, registered.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-011 In IDLE, a rising edge with i_start=1 SHALL capture i_multiplicand and i_multiplier into internal registers, clear the 2N-bit accumulator and the iteration counter, and enter BUSY.
REQ-012 In IDLE with i_start=0, the block SHALL remain in IDLE.
REQ-013 BUSY SHALL last exactly N cycles; each cycle adds the shifted multiplicand to the accumulator if the current multiplier bit is 1, then advances the shift and the counter (radix-2 shift-add).
REQ-014 On the edge ending the Nth BUSY cycle, the block SHALL load o_product and o_overflow from the final accumulator and enter DONE.
REQ-015 With start captured at edge 0, o_finished SHALL rise after edge N and the latency SHALL be independent of operand values, including zero operands.
REQ-016 In DONE, o_finished SHALL be 1; the block SHALL stay in DONE while i_start=1 and return to IDLE on the first edge with i_start=0.
REQ-017 A held i_start SHALL therefore produce exactly one operation.
REQ-018 In BUSY and DONE, the block SHALL ignore changes to i_multiplicand and i_multiplier and SHALL not resample i_start.
REQ-019 o_product and o_overflow SHALL change only on entry to DONE, retaining the last result through IDLE and BUSY until the next completion.
REQ-020 o_finished SHALL be 0 in IDLE and BUSY.
REQ-021 The iteration counter SHALL be ceil(log2(N+1)) bits wide and SHALL not wrap within an operation.
REQ-022 The accumulator SHALL be 2N bits, and no carry beyond bit 2N-1 SHALL be possible: (2^N-1)^2 < 2^2N.

Reset
REQ-023 Asserting i_reset SHALL immediately, without waiting for a clock edge, force state IDLE, o_finished=0, o_product=0, o_overflow=0, counter=0, accumulator=0, and operand registers=0.
REQ-024 Reset during BUSY or DONE SHALL abort the operation, with no partial result appearing on o_product.
REQ-025 After i_reset deasserts, the first edge with i_start=1 SHALL start a new operation normally.

Verification (N=4)
REQ-026 Reset, then A=3, B=5, 1-cycle start pulse -> o_finished rises after 4th edge post-capture; o_product=8'h0F; o_overflow=0.
REQ-027 A=15, B=15 -> o_product=8'hE1 (225); o_overflow=1; latency 4 cycles.
REQ-028 A=0, B=9, then A=9, B=0 -> o_product=0, o_overflow=0 each time, latency still 4 cycles.
REQ-029 i_start held high for 20 cycles with A=6, B=7 -> exactly one DONE entry; o_product=8'h2A; o_finished stays 1 until i_start falls, then 0 next edge; o_product holds 8'h2A.
REQ-030 Start with A=4, B=4, then change inputs to A=15, B=15 on cycle 2 of BUSY -> o_product=8'h10, o_overflow=1.
REQ-031 Start with A=7, B=7, assert i_reset asynchronously mid-cycle in BUSY cycle 2 -> outputs 0 immediately, state IDLE; after release, A=2, B=3 start -> o_product=8'h06 after 4 cycles.
